// File: rtl/axi_lite_pkg.sv
// Shared response codes and channel FSM encodings
// for the AXI4-Lite register slave.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } w_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_t;

endpackage

// File: rtl/axi_lite_regfile.sv
// Register storage with one byte-enabled write port
// and one asynchronous read port.
module axi_lite_regfile
   import axi_lite_pkg::*;
#(
   parameter int NUM_REGS   = 8,
   parameter int DATA_WIDTH = 32,
   parameter int IDX        = $clog2(NUM_REGS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    we,
   input  logic [IDX-1:0]          widx,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic [IDX-1:0]          ridx,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [DATA_WIDTH-1:0]   reg0
);

   logic [DATA_WIDTH-1:0] mem [NUM_REGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (wstrb[b]) begin
               mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = mem[ridx];
   assign reg0  = mem[0];

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing a small register bank; the top
// index reads back status_in, reg[0] drives ctrl_out.
module axi_lite_reg_slave
   import axi_lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic                    arvalid,
   output logic                    arready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    rvalid,
   input  logic                    rready,
   output logic [DATA_WIDTH-1:0]   ctrl_out,
   input  logic [DATA_WIDTH-1:0]   status_in
);

   localparam int IDX = $clog2(NUM_REGS);
   localparam logic [IDX-1:0] RO_IDX = IDX'(NUM_REGS - 1);

   w_state_t w_state;
   r_state_t r_state;

   logic                    aw_held;
   logic                    w_held;
   logic [ADDR_WIDTH-1:0]   awaddr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH/8-1:0] wstrb_q;

   logic                    aw_fire;
   logic                    w_fire;
   logic                    commit;
   logic [ADDR_WIDTH-1:0]   c_addr;
   logic [DATA_WIDTH-1:0]   c_data;
   logic [DATA_WIDTH/8-1:0] c_strb;
   logic [IDX-1:0]          c_idx;
   logic                    c_err;
   logic                    we;

   logic [IDX-1:0]          r_idx;
   logic                    r_oor;
   logic [DATA_WIDTH-1:0]   rf_rdata;

   assign awready = (w_state == W_IDLE) && !aw_held;
   assign wready  = (w_state == W_IDLE) && !w_held;
   assign arready = (r_state == R_IDLE);

   assign aw_fire = awvalid && awready;
   assign w_fire  = wvalid && wready;

   // Commit on the edge that completes the pair, using
   // live channel values for whichever half arrives now.
   assign commit = (w_state == W_IDLE)
                && (aw_held || aw_fire)
                && (w_held || w_fire);

   assign c_addr = aw_held ? awaddr_q : awaddr;
   assign c_data = w_held ? wdata_q : wdata;
   assign c_strb = w_held ? wstrb_q : wstrb;
   assign c_idx  = c_addr[IDX+1:2];
   assign c_err  = ((c_addr >> (IDX + 2)) != '0)
                || (c_idx == RO_IDX);
   assign we     = commit && !c_err;

   assign r_idx = araddr[IDX+1:2];
   assign r_oor = (araddr >> (IDX + 2)) != '0;

   axi_lite_regfile #(
      .NUM_REGS   (NUM_REGS),
      .DATA_WIDTH (DATA_WIDTH),
      .IDX        (IDX)
   ) u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .widx  (c_idx),
      .wdata (c_data),
      .wstrb (c_strb),
      .ridx  (r_idx),
      .rdata (rf_rdata),
      .reg0  (ctrl_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state  <= W_IDLE;
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         awaddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bvalid   <= 1'b0;
         bresp    <= RESP_OKAY;
      end else begin
         unique case (w_state)
            W_IDLE: begin
               if (commit) begin
                  bvalid  <= 1'b1;
                  bresp   <= c_err ? RESP_SLVERR : RESP_OKAY;
                  w_state <= W_RESP;
                  aw_held <= 1'b0;
                  w_held  <= 1'b0;
               end else begin
                  if (aw_fire) begin
                     aw_held  <= 1'b1;
                     awaddr_q <= awaddr;
                  end
                  if (w_fire) begin
                     w_held  <= 1'b1;
                     wdata_q <= wdata;
                     wstrb_q <= wstrb;
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid  <= 1'b0;
                  w_state <= W_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= R_IDLE;
         rvalid  <= 1'b0;
         rresp   <= RESP_OKAY;
         rdata   <= '0;
      end else begin
         unique case (r_state)
            R_IDLE: begin
               if (arvalid) begin
                  rvalid  <= 1'b1;
                  r_state <= R_DATA;
                  rresp   <= r_oor ? RESP_SLVERR : RESP_OKAY;
                  if (r_oor)
                     rdata <= '0;
                  else if (r_idx == RO_IDX)
                     rdata <= status_in;
                  else
                     rdata <= rf_rdata;
               end
            end
            R_DATA: begin
               if (rready) begin
                  rvalid  <= 1'b0;
                  r_state <= R_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave with
// hand-computed expected values.
module tb_axi_lite_reg_slave;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [31:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [31:0] ctrl_out;
   logic [31:0] status_in = '0;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [1:0]  resp;
   logic [31:0] data;

   always #5 clk = ~clk;

   axi_lite_reg_slave dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .awaddr    (awaddr),
      .awvalid   (awvalid),
      .awready   (awready),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .wvalid    (wvalid),
      .wready    (wready),
      .bresp     (bresp),
      .bvalid    (bvalid),
      .bready    (bready),
      .araddr    (araddr),
      .arvalid   (arvalid),
      .arready   (arready),
      .rdata     (rdata),
      .rresp     (rresp),
      .rvalid    (rvalid),
      .rready    (rready),
      .ctrl_out  (ctrl_out),
      .status_in (status_in)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic aw_send(input logic [31:0] a);
      int n = 0;
      @(negedge clk);
      awaddr  = a;
      awvalid = 1'b1;
      while (!awready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("awready", {31'd0, awready}, 32'd1);
      @(posedge clk);
      #1 awvalid = 1'b0;
   endtask

   task automatic w_send(input logic [31:0] d,
                         input logic [3:0] s);
      int n = 0;
      @(negedge clk);
      wdata  = d;
      wstrb  = s;
      wvalid = 1'b1;
      while (!wready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("wready", {31'd0, wready}, 32'd1);
      @(posedge clk);
      #1 wvalid = 1'b0;
   endtask

   task automatic b_take(output logic [1:0] r);
      int n = 0;
      @(negedge clk);
      while (!bvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("bvalid", {31'd0, bvalid}, 32'd1);
      r = bresp;
      bready = 1'b1;
      @(posedge clk);
      #1 bready = 1'b0;
   endtask

   task automatic write(input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0] s,
                        output logic [1:0] r);
      aw_send(a);
      w_send(d, s);
      b_take(r);
   endtask

   task automatic read(input logic [31:0] a,
                       output logic [31:0] d,
                       output logic [1:0] r);
      int n = 0;
      @(negedge clk);
      araddr  = a;
      arvalid = 1'b1;
      while (!arready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("arready", {31'd0, arready}, 32'd1);
      @(posedge clk);
      #1 arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rvalid", {31'd0, rvalid}, 32'd1);
      d = rdata;
      r = rresp;
      rready = 1'b1;
      @(posedge clk);
      #1 rready = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_awready", {31'd0, awready}, 32'd1);
      check("rst_bvalid", {31'd0, bvalid}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_wready", {31'd0, wready}, 32'd1);
      check("rst_arready", {31'd0, arready}, 32'd1);
      check("rst_rvalid", {31'd0, rvalid}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_ctrl", ctrl_out, 32'd0);

      // AW first, W two cycles later
      aw_send(32'h04);
      repeat (2) @(posedge clk);
      #1;
      check("aw_only_bvalid", {31'd0, bvalid}, 32'd0);
      check("aw_only_awready", {31'd0, awready}, 32'd0);
      w_send(32'hDEADBEEF, 4'hF);
      check("b_latency", {31'd0, bvalid}, 32'd1);
      b_take(resp);
      check("bresp_r1", {30'd0, resp}, 32'd0);
      read(32'h04, data, resp);
      check("rd_r1", data, 32'hDEADBEEF);
      check("rresp_r1", {30'd0, resp}, 32'd0);

      // partial strobe
      write(32'h04, 32'h11223344, 4'b0101, resp);
      check("bresp_strb", {30'd0, resp}, 32'd0);
      read(32'h04, data, resp);
      check("rd_strb", data, 32'hDE22BE44);

      // AW and W in the same cycle, low addr bits ignored
      @(negedge clk);
      awaddr = 32'h0B;  awvalid = 1'b1;
      wdata = 32'h5A5A1234;  wstrb = 4'hF;  wvalid = 1'b1;
      @(posedge clk);
      #1 awvalid = 1'b0;  wvalid = 1'b0;
      check("same_bvalid", {31'd0, bvalid}, 32'd1);
      b_take(resp);
      check("same_bresp", {30'd0, resp}, 32'd0);
      read(32'h08, data, resp);
      check("rd_r2", data, 32'h5A5A1234);

      // wstrb=0 leaves the register alone
      write(32'h08, 32'hFFFFFFFF, 4'h0, resp);
      check("bresp_nostrb", {30'd0, resp}, 32'd0);
      read(32'h08, data, resp);
      check("rd_nostrb", data, 32'h5A5A1234);

      // read-only status register
      status_in = 32'hCAFE0001;
      write(32'h1C, 32'h12345678, 4'hF, resp);
      check("bresp_ro", {30'd0, resp}, 32'd2);
      check("ro_ctrl", ctrl_out, 32'd0);
      read(32'h1C, data, resp);
      check("rd_status", data, 32'hCAFE0001);
      check("rresp_status", {30'd0, resp}, 32'd0);

      // out of range aliases idx 0 in its low bits
      write(32'h100, 32'h77777777, 4'hF, resp);
      check("bresp_oor", {30'd0, resp}, 32'd2);
      check("oor_ctrl", ctrl_out, 32'd0);
      read(32'h100, data, resp);
      check("rd_oor", data, 32'd0);
      check("rresp_oor", {30'd0, resp}, 32'd2);

      write(32'h00, 32'hA5A50F0F, 4'hF, resp);
      check("ctrl_out", ctrl_out, 32'hA5A50F0F);

      // read and commit to the same register on one edge
      @(negedge clk);
      araddr = 32'h08;  arvalid = 1'b1;
      awaddr = 32'h08;  awvalid = 1'b1;
      wdata = 32'h0BADF00D;  wstrb = 4'hF;  wvalid = 1'b1;
      @(posedge clk);
      #1 arvalid = 1'b0;  awvalid = 1'b0;  wvalid = 1'b0;
      check("raw_rvalid", {31'd0, rvalid}, 32'd1);
      check("raw_old", rdata, 32'h5A5A1234);
      @(negedge clk);
      rready = 1'b1;  bready = 1'b1;
      @(posedge clk);
      #1 rready = 1'b0;  bready = 1'b0;
      read(32'h08, data, resp);
      check("raw_new", data, 32'h0BADF00D);

      // stalled B channel with a concurrent read
      aw_send(32'h0C);
      w_send(32'h33333333, 4'hF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_bvalid", {31'd0, bvalid}, 32'd1);
         check("stall_bresp", {30'd0, bresp}, 32'd0);
         check("stall_awready", {31'd0, awready}, 32'd0);
         check("stall_wready", {31'd0, wready}, 32'd0);
      end
      read(32'h04, data, resp);
      check("stall_rd", data, 32'hDE22BE44);
      check("stall_bvalid2", {31'd0, bvalid}, 32'd1);
      b_take(resp);
      check("stall_bresp2", {30'd0, resp}, 32'd0);
      read(32'h0C, data, resp);
      check("rd_r3", data, 32'h33333333);

      // reset while W is held
      w_send(32'h99999999, 4'hF);
      check("held_wready", {31'd0, wready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_ctrl", ctrl_out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_ctrl", ctrl_out, 32'd0);
      check("post_bvalid", {31'd0, bvalid}, 32'd0);
      check("post_awready", {31'd0, awready}, 32'd1);
      check("post_wready", {31'd0, wready}, 32'd1);
      check("post_arready", {31'd0, arready}, 32'd1);
      aw_send(32'h00);
      repeat (2) @(negedge clk);
      check("no_stale_commit", {31'd0, bvalid}, 32'd0);
      w_send(32'h00000042, 4'h1);
      b_take(resp);
      check("post_write", ctrl_out, 32'h00000042);

      $display("== %0d vectors applied, %0d miscompares ==",
               vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
